// File: rtl/wb_redirect_unit.sv
// wb_redirect_unit: writeback register-file write, branch/jump redirect and post-redirect flush
module wb_redirect_unit #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid_wb,
  input  logic [1:0]       writeBackControl_wb,
  input  logic             regWrt_wb,
  input  logic [5:0]       rd_wb,
  input  logic             branchZero_wb,
  input  logic             branchNeg_wb,
  input  logic             jump_wb,
  input  logic             jumpMem_wb,
  input  logic [31:0]      pc_plus_y_wb,
  input  logic [31:0]      xrs_wb,
  input  logic [31:0]      readData_wb,
  input  logic [31:0]      aluResult_wb,
  input  logic             z_wb,
  input  logic             n_wb,
  output logic             reg_we,
  output logic [5:0]       reg_waddr,
  output logic [31:0]      reg_wdata,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             flush,
  output logic [CNT_W-1:0] retired_count
);
  localparam logic [0:0] IDLE = 1'b0, FLUSH = 1'b1;
  logic [0:0] state;
  logic [3:0] cnt;
  logic live, taken, sel_ok;
  logic [31:0] wdata_n, target_n;
  always_comb begin
    live = valid_wb & (state == IDLE);
    taken = jumpMem_wb | jump_wb | (branchZero_wb & z_wb) | (branchNeg_wb & n_wb);
    sel_ok = writeBackControl_wb != 2'b11;
    wdata_n = writeBackControl_wb == 2'b00 ? aluResult_wb :
              writeBackControl_wb == 2'b01 ? readData_wb : pc_plus_y_wb;
    target_n = jumpMem_wb ? readData_wb : xrs_wb;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      reg_we <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      pc_redirect <= 1'b0;
      pc_target <= '0;
      retired_count <= '0;
    end else begin
      reg_we <= live & regWrt_wb & sel_ok;
      pc_redirect <= live & taken;
      if (live) reg_waddr <= rd_wb;
      if (live & sel_ok) reg_wdata <= wdata_n;
      if (live & taken) pc_target <= target_n;
      retired_count <= retired_count + CNT_W'(live);
      // flush counts down every cycle regardless of the incoming slot
      if (state == FLUSH) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= IDLE;
      end else if (live & taken) begin
        state <= FLUSH;
        cnt <= 4'(FLUSH_DEPTH);
      end
    end
  assign flush = state == FLUSH;
endmodule

// File: tb/tb_wb_redirect_unit.sv
// tb_wb_redirect_unit: directed vector table, reset-during-flush sequence, randomized model check
module tb_wb_redirect_unit;
  localparam int FD = 2;
  logic clock = 1'b0, reset_n = 1'b0;
  logic valid_wb, regWrt_wb, branchZero_wb, branchNeg_wb, jump_wb, jumpMem_wb, z_wb, n_wb;
  logic [1:0] writeBackControl_wb;
  logic [5:0] rd_wb;
  logic [31:0] pc_plus_y_wb, xrs_wb, readData_wb, aluResult_wb;
  logic reg_we, pc_redirect, flush;
  logic [5:0] reg_waddr;
  logic [31:0] reg_wdata, pc_target, retired_count;

  wb_redirect_unit #(.FLUSH_DEPTH(FD), .CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .valid_wb(valid_wb),
    .writeBackControl_wb(writeBackControl_wb), .regWrt_wb(regWrt_wb), .rd_wb(rd_wb),
    .branchZero_wb(branchZero_wb), .branchNeg_wb(branchNeg_wb), .jump_wb(jump_wb),
    .jumpMem_wb(jumpMem_wb), .pc_plus_y_wb(pc_plus_y_wb), .xrs_wb(xrs_wb),
    .readData_wb(readData_wb), .aluResult_wb(aluResult_wb), .z_wb(z_wb), .n_wb(n_wb),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .flush(flush),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic v; logic [1:0] sel; logic wr; logic [5:0] rd;
    logic bz, bn, j, jm, z, n;
    logic [31:0] alu, rdat, ppy, xrs;
    logic e_we; logic [5:0] e_waddr; logic [31:0] e_wdata;
    logic e_redir; logic [31:0] e_target; logic e_flush; logic [31:0] e_cnt;
  } vec_t;

  int total = 0, bad = 0;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    valid_wb = t.v; writeBackControl_wb = t.sel; regWrt_wb = t.wr; rd_wb = t.rd;
    branchZero_wb = t.bz; branchNeg_wb = t.bn; jump_wb = t.j; jumpMem_wb = t.jm;
    z_wb = t.z; n_wb = t.n; aluResult_wb = t.alu; readData_wb = t.rdat;
    pc_plus_y_wb = t.ppy; xrs_wb = t.xrs;
  endtask

  task automatic idle_inputs();
    valid_wb = 0; writeBackControl_wb = 0; regWrt_wb = 0; rd_wb = 0;
    branchZero_wb = 0; branchNeg_wb = 0; jump_wb = 0; jumpMem_wb = 0;
    z_wb = 0; n_wb = 0; aluResult_wb = 0; readData_wb = 0; pc_plus_y_wb = 0; xrs_wb = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 32'(reg_we), 0);
    chk({tag, "_waddr"}, 32'(reg_waddr), 0);
    chk({tag, "_wdata"}, reg_wdata, 0);
    chk({tag, "_redir"}, 32'(pc_redirect), 0);
    chk({tag, "_target"}, pc_target, 0);
    chk({tag, "_flush"}, 32'(flush), 0);
    chk({tag, "_cnt"}, retired_count, 0);
  endtask

  // reference model: remaining squash slots plus last committed values
  int m_left;
  logic m_we, m_redir, m_live, m_taken;
  logic [5:0] m_waddr;
  logic [31:0] m_wdata, m_target, m_cnt;

  initial begin
    //            v sel wr rd  bz bn j jm z n  alu          rdat          ppy       xrs       we waddr wdata         rdr target    fl cnt
    tbl[0]  = '{1, 0, 1, 5,  0, 0, 0, 0, 0, 0, 32'h1234, 0,            0,        0,        1, 5,  32'h1234,     0, 0,         0, 1};
    tbl[1]  = '{1, 1, 1, 6,  0, 0, 0, 0, 0, 0, 0,        32'hDEADBEEF, 0,        0,        1, 6,  32'hDEADBEEF, 0, 0,         0, 2};
    tbl[2]  = '{1, 2, 1, 9,  0, 0, 0, 0, 0, 0, 0,        0,            32'h40,   0,        1, 9,  32'h40,       0, 0,         0, 3};
    tbl[3]  = '{1, 3, 1, 9,  0, 0, 0, 0, 0, 0, 32'h99,   32'h98,       32'h97,   0,        0, 9,  32'h40,       0, 0,         0, 4};
    tbl[4]  = '{1, 0, 0, 9,  1, 0, 0, 0, 1, 0, 32'h40,   0,            0,        32'h100,  0, 9,  32'h40,       1, 32'h100,   1, 5};
    tbl[5]  = '{1, 0, 1, 7,  0, 0, 0, 0, 0, 0, 32'h777,  0,            0,        0,        0, 9,  32'h40,       0, 32'h100,   1, 5};
    tbl[6]  = '{1, 0, 1, 7,  0, 0, 0, 0, 0, 0, 32'h777,  0,            0,        0,        0, 9,  32'h40,       0, 32'h100,   0, 5};
    tbl[7]  = '{1, 0, 1, 8,  0, 0, 0, 0, 0, 0, 32'h888,  0,            0,        0,        1, 8,  32'h888,      0, 32'h100,   0, 6};
    tbl[8]  = '{1, 0, 0, 8,  1, 1, 0, 0, 0, 0, 32'h888,  0,            0,        32'h180,  0, 8,  32'h888,      0, 32'h100,   0, 7};
    tbl[9]  = '{1, 0, 0, 8,  0, 0, 1, 1, 0, 0, 32'h888,  32'h200,      0,        32'h300,  0, 8,  32'h888,      1, 32'h200,   1, 8};
    tbl[10] = '{1, 0, 1, 8,  0, 0, 1, 0, 0, 0, 32'h555,  0,            0,        32'h500,  0, 8,  32'h888,      0, 32'h200,   1, 8};
    tbl[11] = '{0, 0, 0, 8,  0, 0, 0, 0, 0, 0, 0,        0,            0,        0,        0, 8,  32'h888,      0, 32'h200,   0, 8};
    tbl[12] = '{0, 0, 1, 8,  0, 0, 1, 0, 0, 0, 32'h666,  0,            0,        32'h600,  0, 8,  32'h888,      0, 32'h200,   0, 8};
    tbl[13] = '{1, 2, 1, 63, 0, 0, 0, 0, 0, 0, 0,        0,            32'hABCD, 0,        1, 63, 32'hABCD,     0, 32'h200,   0, 9};

    idle_inputs();
    #12;
    chk_all_zero("reset");
    @(negedge clock) reset_n = 1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i]);
      @(posedge clock) #1;
      chk($sformatf("v%0d_we", i), 32'(reg_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_waddr", i), 32'(reg_waddr), 32'(tbl[i].e_waddr));
      chk($sformatf("v%0d_wdata", i), reg_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_redir", i), 32'(pc_redirect), 32'(tbl[i].e_redir));
      chk($sformatf("v%0d_target", i), pc_target, tbl[i].e_target);
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
      chk($sformatf("v%0d_cnt", i), retired_count, tbl[i].e_cnt);
    end

    // reset asserted in the first flush cycle aborts everything at once
    idle_inputs();
    valid_wb = 1; jump_wb = 1; xrs_wb = 32'h700;
    @(posedge clock) #1;
    chk("rf_flush_on", 32'(flush), 1);
    chk("rf_redir_on", 32'(pc_redirect), 1);
    #2 reset_n = 0;
    #1;
    chk_all_zero("rf_async");
    @(negedge clock) reset_n = 1;
    idle_inputs();
    valid_wb = 1; regWrt_wb = 1; rd_wb = 3; aluResult_wb = 32'h33;
    @(posedge clock) #1;
    chk("rf_post_we", 32'(reg_we), 1);
    chk("rf_post_waddr", 32'(reg_waddr), 3);
    chk("rf_post_wdata", reg_wdata, 32'h33);
    chk("rf_post_flush", 32'(flush), 0);
    chk("rf_post_cnt", retired_count, 1);

    // randomized run against the model
    idle_inputs();
    reset_n = 0;
    #3;
    m_left = 0; m_we = 0; m_redir = 0; m_waddr = 0; m_wdata = 0; m_target = 0; m_cnt = 0;
    @(negedge clock) reset_n = 1;
    for (int c = 0; c < 400; c++) begin
      valid_wb = $urandom_range(0, 3) != 0;
      writeBackControl_wb = 2'($urandom);
      regWrt_wb = 1'($urandom);
      rd_wb = 6'($urandom);
      branchZero_wb = $urandom_range(0, 7) == 0;
      branchNeg_wb = $urandom_range(0, 7) == 0;
      jump_wb = $urandom_range(0, 11) == 0;
      jumpMem_wb = $urandom_range(0, 11) == 0;
      z_wb = 1'($urandom);
      n_wb = 1'($urandom);
      aluResult_wb = $urandom; readData_wb = $urandom; pc_plus_y_wb = $urandom; xrs_wb = $urandom;
      m_live = valid_wb && m_left == 0;
      m_taken = jumpMem_wb || jump_wb || (branchZero_wb && z_wb) || (branchNeg_wb && n_wb);
      m_we = m_live && regWrt_wb && writeBackControl_wb != 2'd3;
      if (m_we) begin
        m_waddr = rd_wb;
        case (writeBackControl_wb)
          2'd0: m_wdata = aluResult_wb;
          2'd1: m_wdata = readData_wb;
          default: m_wdata = pc_plus_y_wb;
        endcase
      end
      m_redir = m_live && m_taken;
      if (m_redir) m_target = jumpMem_wb ? readData_wb : xrs_wb;
      if (m_live) m_cnt = m_cnt + 1;
      if (m_left > 0) m_left = m_left - 1;
      else if (m_redir) m_left = FD;
      @(posedge clock) #1;
      chk($sformatf("r%0d_we", c), 32'(reg_we), 32'(m_we));
      if (m_we) begin
        chk($sformatf("r%0d_waddr", c), 32'(reg_waddr), 32'(m_waddr));
        chk($sformatf("r%0d_wdata", c), reg_wdata, m_wdata);
      end
      chk($sformatf("r%0d_redir", c), 32'(pc_redirect), 32'(m_redir));
      chk($sformatf("r%0d_target", c), pc_target, m_target);
      chk($sformatf("r%0d_flush", c), 32'(flush), 32'(m_left > 0));
      chk($sformatf("r%0d_cnt", c), retired_count, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
